// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - req_op access-size encodings (two encodings both mean "word")
//   - lsu_state_t, the LSU control FSM state enum
//   - is_word(): true for either word encoding
package lsu_pkg;

  localparam logic [1:0] OP_WORD     = 2'b00;
  localparam logic [1:0] OP_BYTE     = 2'b01;
  localparam logic [1:0] OP_HALF     = 2'b10;
  localparam logic [1:0] OP_WORD_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_WR,
    ST_RESP
  } lsu_state_t;

  function automatic logic is_word(input logic [1:0] op);
    return (op == OP_WORD) || (op == OP_WORD_ALT);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundle of the LSU request/response handshake and the word-wide
// data memory port.
//   master : CPU side (drives req_*, resp_ready; sees req_ready, resp_*)
//   slave  : LSU side (mirror of master, plus drives mem_addr/we/wdata and
//            reads mem_rdata)
//   mem    : memory side (sees mem_addr/we/wdata, drives combinational
//            mem_rdata)
interface lsu_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_op;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-3:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_op, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_op, req_unsigned, req_addr, req_wdata, resp_ready,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_we, mem_wdata
  );

  modport mem (
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the LSU.
//   op_i         : access size (lsu_pkg encodings)
//   addr_lo_i    : byte offset within the word
//   unsigned_i   : 1 = zero-extend sub-word loads, 0 = sign-extend
//   rdata_i      : current memory word
//   wdata_i      : store data (low bits used for sub-word stores)
//   load_data_o  : selected lane, extended to 32 bits
//   store_word_o : rdata_i with the store lane replaced (read-modify-write)
//   misalign_o   : access not naturally aligned
// Build option: LSU_ALIGN_CHECK_EN enables misalignment detection; without
// it the offending low address bits are forced to zero and misalign_o is 0.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o,
  output logic        misalign_o
);

  logic [1:0]  eff_addr;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    eff_addr   = addr_lo_i;
    misalign_o = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    case (op_i)
      OP_BYTE: misalign_o = 1'b0;
      OP_HALF: misalign_o = addr_lo_i[0];
      default: misalign_o = (addr_lo_i != 2'b00);
    endcase
`else
    case (op_i)
      OP_BYTE: eff_addr = addr_lo_i;
      OP_HALF: eff_addr = {addr_lo_i[1], 1'b0};
      default: eff_addr = 2'b00;
    endcase
`endif
  end

  assign byte_lane = rdata_i[{eff_addr, 3'b000} +: 8];
  assign half_lane = rdata_i[{eff_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o  = rdata_i;
    store_word_o = wdata_i;
    case (op_i)
      OP_BYTE: begin
        load_data_o  = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
        store_word_o = rdata_i;
        store_word_o[{eff_addr, 3'b000} +: 8] = wdata_i[7:0];
      end
      OP_HALF: begin
        load_data_o  = {{16{~unsigned_i & half_lane[15]}}, half_lane};
        store_word_o = rdata_i;
        store_word_o[{eff_addr[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_data_o  = rdata_i;
        store_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the CPU datapath and a word-wide data memory.
// One request at a time: IDLE -> ACC -> (WR) -> RESP. Sub-word stores are
// read-modify-write (merge in ACC, write in WR) so memory only sees full words.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : lsu_if.slave (request/response handshake + memory word port)
// Build option: LSU_ALIGN_CHECK_EN (see lsu_align) enables resp_err.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input logic   clk,
  input logic   rstn,
  lsu_if.slave  bus
);

  lsu_state_t        state_q, state_d;
  logic [1:0]        op_q;
  logic              we_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic              misalign;
  logic              word_store;
  logic              sub_store;

  lsu_align u_align (
    .op_i         (op_q),
    .addr_lo_i    (addr_q[1:0]),
    .unsigned_i   (uns_q),
    .rdata_i      (bus.mem_rdata),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word),
    .misalign_o   (misalign)
  );

  // A misaligned store never reaches the memory.
  assign word_store = we_q && !misalign && is_word(op_q);
  assign sub_store  = we_q && !misalign && !is_word(op_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.req_valid) begin
        op_q    <= bus.req_op;
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      // Response fields are only written in ACC, so they stay stable in RESP.
      if (state_q == ST_ACC) begin
        merged_q <= store_word;
        err_q    <= misalign;
        if (misalign || we_q) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= load_data;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = ST_ACC;
      end
      ST_ACC: begin
        if (word_store) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = wdata_q;
        end
        state_d = sub_store ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = merged_q;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_addr   = addr_q[ADDR_W-1:2];
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. Holds a word memory wired to the
// memory port and an independent reference memory updated from the
// load/store rules using plain byte arithmetic.
module tb_lsu;

  localparam int ADDR_W = 9;
  localparam int NWORDS = 1 << (ADDR_W - 2);

  logic clk;
  logic rstn;

  lsu_if #(.ADDR_W(ADDR_W)) bus ();

  lsu #(.ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  int          obs_lat;
  int          obs_we_cnt;
  int          obs_we_cyc;
  logic [31:0] obs_we_data;
  logic [31:0] obs_we_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected result of one access, from the size/offset rules.
  function automatic void model(input logic we, input logic [1:0] op, input logic uns,
                                input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                                output logic [31:0] e_rdata, output logic e_err,
                                output logic [31:0] e_word, output int e_lat,
                                output int e_wecnt, output int e_wecyc);
    int idx, bo, size;
    logic [31:0] w, v, mask;
    idx  = int'(addr) / 4;
    bo   = int'(addr) % 4;
    w    = ref_mem[idx];
    size = (op == 2'b01) ? 1 : (op == 2'b10) ? 2 : 4;
    e_err = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    if (bo % size != 0) e_err = 1'b1;
`else
    bo = bo - (bo % size);
`endif
    e_word  = w;
    e_rdata = 32'h0;
    e_wecnt = 0;
    e_wecyc = 0;
    e_lat   = 2;
    if (!e_err) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      if (!we) begin
        v = (w >> (8 * bo)) & mask;
        if (size < 4 && !uns && v[8 * size - 1]) v = v | ~mask;
        e_rdata = v;
      end else begin
        e_word  = (w & ~(mask << (8 * bo))) | ((wdata & mask) << (8 * bo));
        e_wecnt = 1;
        e_wecyc = (size == 4) ? 1 : 2;
        e_lat   = (size == 4) ? 2 : 3;
      end
    end
  endfunction

  task automatic run_req(input logic we, input logic [1:0] op, input logic uns,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                         input int stall, output logic [31:0] rdata, output logic err);
    logic [31:0] e_rdata, e_word, held;
    logic        e_err;
    int          e_lat, e_wecnt, e_wecyc, idx, cyc, wait_cyc;
    logic        got;

    model(we, op, uns, addr, wdata, e_rdata, e_err, e_word, e_lat, e_wecnt, e_wecyc);
    idx = int'(addr) / 4;

    @(negedge clk);
    wait_cyc = 0;
    while (!bus.req_ready && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);

    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_op       = op;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.resp_ready   = 1'b0;
    @(posedge clk);
    #1;
    // Garbage on the request lines while busy must be ignored.
    bus.req_we       = 1'($urandom);
    bus.req_op       = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = ADDR_W'($urandom);
    bus.req_wdata    = $urandom;

    cyc = 0;
    got = 1'b0;
    obs_we_cnt = 0;
    obs_we_cyc = 0;
    obs_we_data = 32'h0;
    obs_we_addr = 32'h0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_we) begin
        obs_we_cnt++;
        obs_we_cyc  = cyc;
        obs_we_data = bus.mem_wdata;
        obs_we_addr = 32'(bus.mem_addr);
      end
      if (bus.resp_valid) got = 1'b1;
    end
    obs_lat = cyc;
    check("resp_timeout", 32'(got), 32'd1);
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    held  = bus.resp_rdata;

    check("latency", 32'(obs_lat), 32'(e_lat));
    check("resp_rdata", rdata, e_rdata);
    check("resp_err", 32'(err), 32'(e_err));
    check("mem_we_count", 32'(obs_we_cnt), 32'(e_wecnt));
    if (e_wecnt > 0) begin
      check("mem_we_cycle", 32'(obs_we_cyc), 32'(e_wecyc));
      check("mem_addr", obs_we_addr, 32'(idx));
      check("mem_wdata", obs_we_data, e_word);
    end

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.resp_valid), 32'd1);
      check("stall_rdata", bus.resp_rdata, held);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_mem_we", 32'(bus.mem_we), 32'd0);
    end

    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check("release_valid", 32'(bus.resp_valid), 32'd0);
    check("release_ready", 32'(bus.req_ready), 32'd1);

    check("mem_content", mem[idx], e_word);
    ref_mem[idx] = e_word;
    n_txn++;
    $display("[TB] txn %0d we=%0d op=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             n_txn, we, op, uns, addr, wdata, rdata, err, obs_lat);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;

    clk = 1'b0;
    rstn = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_op = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;

    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Byte loads from word 0x10.
    run_req(1'b0, 2'b01, 1'b0, 9'h011, 32'h0, 0, rd, er);
    check("tp_lb_signed", rd, 32'hFFFFFFAA);
    check("tp_lb_signed_lat", 32'(obs_lat), 32'd2);
    run_req(1'b0, 2'b01, 1'b1, 9'h011, 32'h0, 0, rd, er);
    check("tp_lb_unsigned", rd, 32'h000000AA);

    // Halfword store, read-modify-write.
    run_req(1'b1, 2'b10, 1'b0, 9'h012, 32'h00001234, 0, rd, er);
    check("tp_sh_we_cnt", 32'(obs_we_cnt), 32'd1);
    check("tp_sh_we_cyc", 32'(obs_we_cyc), 32'd2);
    check("tp_sh_wdata", obs_we_data, 32'h1234AABB);
    check("tp_sh_lat", 32'(obs_lat), 32'd3);

    // Word store then load back.
    run_req(1'b1, 2'b00, 1'b0, 9'h020, 32'hDEADBEEF, 0, rd, er);
    check("tp_sw_we_cyc", 32'(obs_we_cyc), 32'd1);
    check("tp_sw_addr", obs_we_addr, 32'd8);
    check("tp_sw_wdata", obs_we_data, 32'hDEADBEEF);
    run_req(1'b0, 2'b11, 1'b0, 9'h020, 32'h0, 0, rd, er);
    check("tp_lw", rd, 32'hDEADBEEF);

    // Misaligned word load.
    run_req(1'b0, 2'b00, 1'b0, 9'h022, 32'h0, 0, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
    check("tp_mis_err", 32'(er), 32'd1);
    check("tp_mis_rdata", rd, 32'h0);
`else
    check("tp_mis_err", 32'(er), 32'd0);
    check("tp_mis_rdata", rd, 32'hDEADBEEF);
`endif
    check("tp_mis_we", 32'(obs_we_cnt), 32'd0);

    // Consumer stalls for 5 cycles.
    run_req(1'b0, 2'b10, 1'b0, 9'h012, 32'h0, 5, rd, er);
    check("tp_stall_rdata", rd, 32'h00001234);

    // Reset while the sub-word write is pending.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_op = 2'b01;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 9'h031;
    bus.req_wdata = 32'h00000055;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_acc_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    check("rstwr_wr_we", 32'(bus.mem_we), 32'd1);
    rstn = 1'b0;
    #1;
    check("rstwr_mem_we", 32'(bus.mem_we), 32'd0);
    check("rstwr_req_ready", 32'(bus.req_ready), 32'd1);
    check("rstwr_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstwr_resp_rdata", bus.resp_rdata, 32'h0);
    check("rstwr_resp_err", 32'(bus.resp_err), 32'd0);
    check("rstwr_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rstwr_mem_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    check("rstwr_mem_unchanged", mem[12], ref_mem[12]);
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic, mostly in a small window to force reuse.
    for (int t = 0; t < 200; t++) begin
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 63));
      run_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
              int'($urandom_range(0, 2)), rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the CPU datapath and the word-wide data memory. Accepts one load or store request at a time over a valid/ready handshake. Drives the memory's word port (word address, write enable, write data, combinational read data) and performs byte/halfword extraction with sign/zero extension. Implements sub-word stores as read-modify-write so the memory only ever sees full-word writes.

## Interface
- `ADDR_W`, default 9: byte-address width. Memory word address is `[ADDR_W-1:2]`.
- `clk`, in, 1: clock, rising edge.
- `rstn`, in, 1: asynchronous active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: unit can accept a request. High only in IDLE.
- `req_we`, in, 1: 1 means store, 0 means load.
- `req_op`, in, 2: access size. 01 = byte, 10 = halfword, 00 or 11 = word.
- `req_unsigned`, in, 1: zero-extend loads. 0 means sign-extend. Ignored for word loads and for stores.
- `req_addr`, in, ADDR_W: byte address.
- `req_wdata`, in, 32: store data, taken from the low bits for sub-word stores.
- `resp_valid`, out, 1: response present.
- `resp_ready`, in, 1: consumer accepts the response.
- `resp_rdata`, out, 32: extended load data. 0 for stores.
- `resp_err`, out, 1: misaligned access. No memory effect.
- `mem_addr`, out, ADDR_W-2: memory word address.
- `mem_we`, out, 1: memory write enable. Memory writes on the rising clock edge.
- `mem_wdata`, out, 32: full word to write.
- `mem_rdata`, in, 32: combinational read of `mem[mem_addr]`.

## Operation
- States: IDLE, ACC, WR, RESP.
- **IDLE**
  - Request is accepted when `req_valid && req_ready`.
  - On acceptance, latch op, we, unsigned, addr and wdata, then go to ACC.
- **ACC**
  - Drive `mem_addr` = latched `addr[ADDR_W-1:2]`.
  - Load: extract the lane from `mem_rdata`, extend it, register into `resp_rdata`, then go to RESP.
  - Word store: `mem_we`=1, `mem_wdata`=wdata, then go to RESP.
  - Sub-word store: merge the new lane into `mem_rdata`, register the merged word, then go to WR.
- **WR**: `mem_we`=1, `mem_wdata`=merged word, same `mem_addr`, then go to RESP.
- **RESP**: `resp_valid`=1. On `resp_ready`, go to IDLE. Response fields are held stable while stalled.
- Lane selection:
  - Byte: lane `addr[1:0]`, bits `[8*addr[1:0]+7 : 8*addr[1:0]]`.
  - Halfword: `addr[1]` selects bits `[15:0]` or `[31:16]`.
- Extension:
  - Sign-extend replicates bit 7 (byte) or bit 15 (half).
  - Zero-extend pads with 0.
- Misalignment:
  - Halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - ACC goes directly to RESP with `resp_err`=1 and `resp_rdata`=0.
  - `mem_we` is never asserted for a misaligned access.
- `mem_we` is a combinational decode of state and latched fields. It is never high in IDLE or RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset asserted mid-operation aborts it and `mem_we` drops immediately. A pending WR is not performed.
- Acceptance to `resp_valid`:
  - 2 cycles for loads, word stores and misaligned accesses.
  - 3 cycles for sub-word stores.
- Back-to-back throughput is limited by the IDLE cycle: one request per 3 cycles minimum, 4 for sub-word stores.
- `req_*` inputs are ignored outside IDLE. The unit accepts no new request in the cycle it leaves RESP.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: misalignment detected as above.
- Undefined:
  - No check. Halfword addresses have bit 0 forced to 0; word addresses have bits `[1:0]` forced to 0.
  - `resp_err` is tied to 0.

## Structure
- `lsu_pkg` holds:
  - `req_op` encodings `OP_BYTE`=2'b01, `OP_HALF`=2'b10, `OP_WORD`=2'b00/2'b11.
  - The state enum `lsu_state_t`.
- One combinational sub-module, `lsu_align`. Inputs: op, `addr[1:0]`, unsigned, `mem_rdata`, wdata. Outputs: extended load data, merged store word, misalign flag.
- The FSM and registers live in `lsu`.

## Test plan
- Memory word 0x10 (`mem_addr`=4) = 0x8899AABB. Byte load addr 0x11, signed → `resp_rdata`=0xFFFFFFAA, `resp_valid` 2 cycles after acceptance. Same with unsigned → 0x000000AA.
- Half store addr 0x12, `req_wdata`=0x00001234, memory initially 0x8899AABB:
  - one `mem_we` pulse, 2 cycles after acceptance, `mem_wdata`=0x1234AABB;
  - `resp_valid` at cycle 3.
- Word store addr 0x20, 0xDEADBEEF → `mem_we` in ACC, `mem_addr`=8, `mem_wdata`=0xDEADBEEF. Subsequent word load from 0x20 returns 0xDEADBEEF.
- Word load addr 0x22 with `LSU_ALIGN_CHECK_EN` → `resp_err`=1, `resp_rdata`=0, no `mem_we`. Without the macro → reads word 0x20, `resp_err`=0.
- `resp_ready` held 0 for 5 cycles → `resp_valid` and `resp_rdata` stable, `req_ready`=0. Release → IDLE next cycle.
- `rstn` pulsed low while in WR → `mem_we` 0 during reset, memory unchanged, all outputs at reset values.
